bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter for one crossbar slave port. Watches the Avalon read/write
//  requests of NUM_INPUTS masters and the slave's waitrequest, and drives the
//  select code (0 = none, i+1 = master i) of the bus multiplexer directly downstream.
//  Holds a grant until the transfer is accepted, withdrawn or timed out. The slave
//  must return read data on the cycle after acceptance.
// PARAMETERS
//  NUM_INPUTS  2    number of masters competing for this slave (>=1)
//  TIMEOUT     256  max grant cycles with waitrequest high before a forced release; 0 = disabled
//  SEL_W       localparam = $clog2(NUM_INPUTS+1), width of select codes
// PORTS
//  i_Clk                in   1           clock; all logic on rising edge
//  i_Rst                in   1           synchronous reset, active-high
//  i_AVIn_Read          in   NUM_INPUTS  per-master Avalon read request
//  i_AVIn_Write         in   NUM_INPUTS  per-master Avalon write request
//  i_AVOut_WaitRequest  in   1           slave waitrequest (slave side of the mux)
//  o_MuxSel             out  SEL_W       mux select: 0 = idle, i+1 = master i granted
//  o_Grant              out  NUM_INPUTS  one-hot grant, all-zero when o_MuxSel == 0
//  o_Busy               out  1           1 while in GRANT state
//  o_Timeout            out  1           one-cycle pulse on forced release
//  o_TimeoutMaster      out  SEL_W       select code (i+1) of last timed-out master; held
// BEHAVIOUR
//  - req[i] = i_AVIn_Read[i] | i_AVIn_Write[i]. All outputs are registered.
//  - Reset (i_Rst=1 at an edge): state=IDLE; o_MuxSel, o_Grant, o_Busy, o_Timeout,
//    o_TimeoutMaster = 0; round-robin pointer r_Last = NUM_INPUTS-1, so master 0 wins first;
//    timeout counter = 0. Reset during GRANT abandons the transfer; outputs are 0 the next cycle.
//  - IDLE: o_MuxSel=0. If any req, pick the first requesting index g scanning
//    r_Last+1, r_Last+2, ... modulo NUM_INPUTS. Next cycle: state=GRANT,
//    o_MuxSel=g+1, o_Grant[g]=1, o_Busy=1. If there is no req, stay in IDLE.
//  - GRANT (granted index g). Evaluated each cycle in this priority order:
//    1. accept: req[g] & !i_AVOut_WaitRequest -> IDLE, r_Last<=g, counter<=0.
//    2. withdraw: !req[g] -> IDLE, r_Last<=g, counter<=0, no timeout flagged.
//    3. timeout: TIMEOUT!=0 and counter==TIMEOUT-1 (waitrequest high) -> IDLE,
//       r_Last<=g, counter<=0, o_Timeout=1 next cycle, o_TimeoutMaster<=g+1.
//    4. otherwise stay in GRANT, counter<=counter+1 (saturating; width $clog2(TIMEOUT+1)).
//    Accept on the same cycle the counter hits the limit counts as accept; no timeout.
//  - On leaving GRANT, o_MuxSel=0 for at least one cycle (IDLE). The mux's delayed
//    read-data steering still points at g in that cycle. Peak throughput is 1 transfer per
//    2 cycles. A granted master is held for the whole wait.
//  - Requests from other masters during GRANT are ignored until the next IDLE.
//  - o_Timeout is high for exactly one cycle per event. o_TimeoutMaster changes only on timeout.
//  - NUM_INPUTS=1: pointer wrap degenerates to index 0; the same FSM applies.
// TESTING
//  1. Reset, then req[0]=read with wait=0 -> cycle+1 o_MuxSel=1, o_Grant=01; cycle+2 o_MuxSel=0.
//  2. NUM_INPUTS=2, both req held high, wait=0 -> o_MuxSel sequence 0,1,0,2,0,1,0,2...
//  3. Master 1 granted, wait high 3 cycles then low -> o_MuxSel=2 for 4 cycles, then 0.
//  4. TIMEOUT=4, master 0 granted, wait stuck high -> o_MuxSel=1 for 4 cycles, then o_MuxSel=0,
//     o_Timeout=1 for 1 cycle, o_TimeoutMaster=1; next grant goes to master 1 if it requests.
//  5. Granted master drops req with wait high -> o_MuxSel=0 next cycle, o_Timeout stays 0,
//     pointer advances. Also run NUM_INPUTS=3 with all requesting -> order 1,2,3,1.
//  6. i_Rst pulsed mid-GRANT -> next cycle all outputs 0; with both requesting, first grant = master 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter driving the select of one crossbar slave-port mux
module bus_arbiter #(
  parameter int NUM_INPUTS = 2,
  parameter int TIMEOUT = 256,
  localparam int SEL_W = $clog2(NUM_INPUTS + 1)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [NUM_INPUTS-1:0] i_AVIn_Read,
  input  logic [NUM_INPUTS-1:0] i_AVIn_Write,
  input  logic                  i_AVOut_WaitRequest,
  output logic [SEL_W-1:0]      o_MuxSel,
  output logic [NUM_INPUTS-1:0] o_Grant,
  output logic                  o_Busy,
  output logic                  o_Timeout,
  output logic [SEL_W-1:0]      o_TimeoutMaster
);
  localparam int IDX_W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [0:0] IDLE = 1'b0, GRANT = 1'b1;
  logic [0:0] state;
  logic [IDX_W-1:0] g, r_last, pick, idx;
  logic [CNT_W-1:0] cnt;
  logic [NUM_INPUTS-1:0] req;
  logic hold, limit;
  assign req = i_AVIn_Read | i_AVIn_Write;
  assign hold = req[g];
  assign limit = TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1);
  // first requester scanning upward from the one after the last served index
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      idx = IDX_W'((int'(r_last) + k) % NUM_INPUTS);
      if (req[idx]) pick = idx;
    end
  end
  // grant on a request from idle; release on accept, withdraw or wait limit
  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      state <= IDLE;
      g <= '0;
      r_last <= IDX_W'(NUM_INPUTS - 1);
      cnt <= '0;
      o_MuxSel <= '0;
      o_Grant <= '0;
      o_Busy <= 1'b0;
      o_Timeout <= 1'b0;
      o_TimeoutMaster <= '0;
    end else begin
      o_Timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state <= GRANT;
          g <= pick;
          cnt <= '0;
          o_MuxSel <= SEL_W'(pick) + SEL_W'(1);
          o_Grant <= NUM_INPUTS'(1) << pick;
          o_Busy <= 1'b1;
        end
      end else if (!hold || !i_AVOut_WaitRequest || limit) begin
        state <= IDLE;
        r_last <= g;
        cnt <= '0;
        o_MuxSel <= '0;
        o_Grant <= '0;
        o_Busy <= 1'b0;
        if (hold && i_AVOut_WaitRequest) begin
          o_Timeout <= 1'b1;
          o_TimeoutMaster <= SEL_W'(g) + SEL_W'(1);
        end
      end else if (cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter against a transaction-level model
module tb_bus_arbiter;
  localparam int N = 3, TO = 4, SW = $clog2(N + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] rd = '0, wr = '0;
  logic wt = 1'b0;
  logic [SW-1:0] mux, tom;
  logic [N-1:0] gnt;
  logic busy, tout;
  int checks = 0, failures = 0;
  int owner = -1, last = N - 1, waited = 0, e_to = 0, e_tom = 0;
  int exp_seq[8] = '{1, 0, 2, 0, 3, 0, 1, 0};
  always #5 clk = ~clk;
  bus_arbiter #(.NUM_INPUTS(N), .TIMEOUT(TO)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_AVIn_Read(rd), .i_AVIn_Write(wr),
    .i_AVOut_WaitRequest(wt), .o_MuxSel(mux), .o_Grant(gnt), .o_Busy(busy),
    .o_Timeout(tout), .o_TimeoutMaster(tom)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic release_bus();
    last = owner;
    owner = -1;
    waited = 0;
  endtask
  task automatic model();
    logic [N-1:0] req;
    req = rd | wr;
    e_to = 0;
    if (rst) begin
      owner = -1;
      last = N - 1;
      waited = 0;
      e_tom = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= N && owner < 0; k++)
        if (req[(last + k) % N]) owner = (last + k) % N;
    end else if (!req[owner] || !wt) release_bus();
    else if (waited + 1 == TO) begin
      e_to = 1;
      e_tom = owner + 1;
      release_bus();
    end else waited++;
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("mux_sel", mux, owner + 1);
    chk("grant", gnt, owner < 0 ? 0 : (1 << owner));
    chk("busy", busy, owner >= 0);
    chk("timeout", tout, e_to);
    chk("timeout_master", tom, e_tom);
  endtask
  task automatic drive(input logic r, input logic [N-1:0] rv, input logic [N-1:0] wv, input logic w);
    rst = r;
    rd = rv;
    wr = wv;
    wt = w;
  endtask
  initial begin
    step();
    chk("reset_sel", mux, 0);
    drive(0, 3'b001, 3'b000, 0);
    step();
    chk("single_sel", mux, 1);
    chk("single_grant", gnt, 3'b001);
    drive(0, 3'b000, 3'b000, 0);
    step();
    chk("single_release", mux, 0);
    drive(1, 3'b000, 3'b000, 0);
    step();
    drive(0, 3'b011, 3'b100, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_order", mux, exp_seq[i]);
    end
    drive(1, 3'b000, 3'b000, 0);
    step();
    drive(0, 3'b001, 3'b000, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_hold", mux, 1);
      if (i == 3) drive(0, 3'b011, 3'b000, 1);
    end
    step();
    chk("to_pulse", tout, 1);
    chk("to_master", tom, 1);
    chk("to_idle", mux, 0);
    step();
    chk("to_next", mux, 2);
    chk("to_once", tout, 0);
    drive(0, 3'b001, 3'b000, 1);
    step();
    chk("withdraw_idle", mux, 0);
    chk("withdraw_noto", tout, 0);
    drive(0, 3'b001, 3'b100, 1);
    step();
    chk("withdraw_ptr", mux, 3);
    drive(1, 3'b011, 3'b000, 1);
    step();
    chk("rst_sel", mux, 0);
    chk("rst_tmaster", tom, 0);
    drive(0, 3'b011, 3'b000, 0);
    step();
    chk("rst_first", mux, 1);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, N'($urandom) & N'($urandom | $urandom),
            N'($urandom) & N'($urandom), $urandom_range(0, 3) != 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
